// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the writeback slice.
// Holds the status and icode encodings, the register IDs, the W pipeline
// register layout with its bubble value, and the status-normalisation helper.
package y86_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned REG_COUNT = 15;
  localparam int unsigned RID_W     = 4;
  localparam int unsigned STAT_W    = 3;
  localparam int unsigned ICODE_W   = 4;

  typedef logic [STAT_W-1:0]  stat_t;
  typedef logic [ICODE_W-1:0] icode_t;
  typedef logic [RID_W-1:0]   rid_t;

  localparam stat_t STAT_AOK = 3'd1;
  localparam stat_t STAT_HLT = 3'd2;
  localparam stat_t STAT_ADR = 3'd3;
  localparam stat_t STAT_INS = 3'd4;

  localparam icode_t I_HALT   = 4'h0;
  localparam icode_t I_NOP    = 4'h1;
  localparam icode_t I_CMOVXX = 4'h2;
  localparam icode_t I_IRMOVQ = 4'h3;
  localparam icode_t I_RMMOVQ = 4'h4;
  localparam icode_t I_MRMOVQ = 4'h5;
  localparam icode_t I_OPQ    = 4'h6;
  localparam icode_t I_JXX    = 4'h7;
  localparam icode_t I_CALL   = 4'h8;
  localparam icode_t I_RET    = 4'h9;
  localparam icode_t I_PUSHQ  = 4'hA;
  localparam icode_t I_POPQ   = 4'hB;

  localparam rid_t RNONE = 4'hF;
  localparam rid_t RRSP  = 4'h4;

  // W pipeline register payload
  typedef struct packed {
    stat_t             stat;
    icode_t            icode;
    logic [WORD_W-1:0] valE;
    logic [WORD_W-1:0] valM;
    rid_t              dstE;
    rid_t              dstM;
    logic              cnd;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    valE:  '0,
    valM:  '0,
    dstE:  RNONE,
    dstM:  RNONE,
    cnd:   1'b0
  };

  // Unknown status encodings are folded into INS
  function automatic stat_t norm_stat(input stat_t s);
    if (s == STAT_AOK || s == STAT_HLT || s == STAT_ADR || s == STAT_INS) begin
      return s;
    end
    return STAT_INS;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage / decode-stage connection bundle for the writeback stage.
// master: the surrounding pipeline (drives m_*, W_stall/W_bubble, d_src*).
// slave : the writeback stage (drives d_rval*, W_*, prog_stat, halted).
interface writeback_stage_if;
  import y86_pkg::*;

  logic              W_stall;
  logic              W_bubble;
  stat_t             m_stat;
  icode_t            m_icode;
  logic [WORD_W-1:0] m_valE;
  logic [WORD_W-1:0] m_valM;
  rid_t              m_dstE;
  rid_t              m_dstM;
  logic              m_Cnd;
  rid_t              d_srcA;
  rid_t              d_srcB;
  logic [WORD_W-1:0] d_rvalA;
  logic [WORD_W-1:0] d_rvalB;
  stat_t             W_stat;
  icode_t            W_icode;
  logic [WORD_W-1:0] W_valE;
  logic [WORD_W-1:0] W_valM;
  rid_t              W_dstE;
  rid_t              W_dstM;
  stat_t             prog_stat;
  logic              halted;

  modport master (
    output W_stall, W_bubble, m_stat, m_icode, m_valE, m_valM,
           m_dstE, m_dstM, m_Cnd, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, W_stat, W_icode, W_valE, W_valM,
           W_dstE, W_dstM, prog_stat, halted
  );

  modport slave (
    input  W_stall, W_bubble, m_stat, m_icode, m_valE, m_valM,
           m_dstE, m_dstM, m_Cnd, d_srcA, d_srcB,
    output d_rvalA, d_rvalB, W_stat, W_icode, W_valE, W_valM,
           W_dstE, W_dstM, prog_stat, halted
  );

endinterface

// File: rtl/writeback_stage_regfile.sv
// Architectural register file: NREG x XLEN storage, async reset to zero.
// Ports: i_we_e/i_dst_e/i_val_e and i_we_m/i_dst_m/i_val_m are the two
// synchronous write ports (M wins on a shared destination); i_src_a/i_src_b
// select the two combinational read ports o_rdata_a/o_rdata_b (ID F reads 0).
module writeback_stage_regfile #(
  parameter int unsigned NREG = 15,
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we_e,
  input  logic [3:0]      i_dst_e,
  input  logic [XLEN-1:0] i_val_e,
  input  logic            i_we_m,
  input  logic [3:0]      i_dst_m,
  input  logic [XLEN-1:0] i_val_m,
  input  logic [3:0]      i_src_a,
  input  logic [3:0]      i_src_b,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b
);

  logic [XLEN-1:0] r_regs [NREG];

  // The M write is issued last so it overrides E on the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (i_we_e && (i_dst_e < 4'(NREG))) begin
        r_regs[i_dst_e] <= i_val_e;
      end
      if (i_we_m && (i_dst_m < 4'(NREG))) begin
        r_regs[i_dst_m] <= i_val_m;
      end
    end
  end

  assign o_rdata_a = (i_src_a < 4'(NREG)) ? r_regs[i_src_a] : '0;
  assign o_rdata_b = (i_src_b < 4'(NREG)) ? r_regs[i_src_b] : '0;

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: W pipeline register, register-file commit and
// sticky program status.
// Ports: clk, rst (async, active high); wb (slave side of
// writeback_stage_if) carries the m_* inputs, W_stall/W_bubble control,
// decode read ports d_src*/d_rval*, the W_* forwarding outputs, prog_stat
// and halted.
module writeback_stage
  import y86_pkg::*;
#(
  parameter int unsigned NREG = REG_COUNT,
  parameter int unsigned XLEN = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  writeback_stage_if.slave  wb
);

  w_reg_t r_w;
  logic   r_halted;
  stat_t  r_prog_stat;

  logic   w_commit;
  rid_t   w_dste_eff;
  logic   w_we_e;
  logic   w_we_m;

  // W pipeline register: stall beats bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w <= W_BUBBLE;
    end else if (wb.W_stall) begin
      r_w <= r_w;
    end else if (wb.W_bubble) begin
      r_w <= W_BUBBLE;
    end else begin
      r_w <= '{
        stat:  norm_stat(wb.m_stat),
        icode: wb.m_icode,
        valE:  wb.m_valE,
        valM:  wb.m_valM,
        dstE:  wb.m_dstE,
        dstM:  wb.m_dstM,
        cnd:   wb.m_Cnd
      };
    end
  end

  // First non-AOK instruction reaching W latches its status and stops commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted    <= 1'b0;
      r_prog_stat <= STAT_AOK;
    end else if (!r_halted && (r_w.stat != STAT_AOK)) begin
      r_halted    <= 1'b1;
      r_prog_stat <= r_w.stat;
    end
  end

  // A not-taken conditional move writes nothing
  assign w_dste_eff = ((r_w.icode == I_CMOVXX) && !r_w.cnd) ? RNONE : r_w.dstE;
  assign w_commit   = !r_halted && (r_w.stat == STAT_AOK);
  assign w_we_e     = w_commit && (w_dste_eff != RNONE);
  assign w_we_m     = w_commit && (r_w.dstM != RNONE);

  writeback_stage_regfile #(
    .NREG (NREG),
    .XLEN (XLEN)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we_e    (w_we_e),
    .i_dst_e   (w_dste_eff),
    .i_val_e   (r_w.valE),
    .i_we_m    (w_we_m),
    .i_dst_m   (r_w.dstM),
    .i_val_m   (r_w.valM),
    .i_src_a   (wb.d_srcA),
    .i_src_b   (wb.d_srcB),
    .o_rdata_a (wb.d_rvalA),
    .o_rdata_b (wb.d_rvalB)
  );

  assign wb.W_stat    = r_w.stat;
  assign wb.W_icode   = r_w.icode;
  assign wb.W_valE    = r_w.valE;
  assign wb.W_valM    = r_w.valM;
  assign wb.W_dstE    = r_w.dstE;
  assign wb.W_dstM    = r_w.dstM;
  assign wb.prog_stat = r_prog_stat;
  assign wb.halted    = r_halted;

endmodule
